dsr_loader: RTL and testbench

Writer side of the TIPI DSR ROM. The Raspberry Pi streams DSR image bytes over a three-wire serial link (strobe, data, frame enable). This block deserializes them and writes them into the 8K DSR block RAM that the TI-99/4A later reads. It sits between the Pi GPIO pins and the write port of the DSR RAM, and reports progress, a running checksum and framing errors back to the Pi.

---
 rtl/dsr_loader.sv | 198 +++++++++++++++++++
 tb/tb_dsr_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsr_loader.sv
// Deserializes a framed three-wire stream from the Pi into writes on the DSR RAM port.
// Each frame carries a 16-bit start address followed by data bytes, MSB first.
module dsr_loader #(
    parameter int ADDR_W      = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pi_sclk,
    input  logic              pi_sdata,
    input  logic              pi_le,
    output logic              ram_we,
    output logic [0:ADDR_W-1] ram_addr,
    output logic [0:7]        ram_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [0:7]        checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] le_sync;
    logic                   sclk_prev;
    logic                   le_prev;

    logic                   sclk_rise;
    logic                   le_rise;
    logic                   le_fall;
    logic                   sdata_bit;

    logic [14:0]            shreg;
    logic [15:0]            shift_word;
    logic [3:0]             bit_cnt;
    logic [ADDR_W-1:0]      addr_cnt;

    logic                   start;
    logic                   do_shift;
    logic                   hdr_load;
    logic                   hdr_bad;
    logic                   byte_load;
    logic                   frame_end;
    logic                   frame_err;

    // The Pi pins are asynchronous to clk, so every one of them goes through its own chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            le_sync    <= '0;
            sclk_prev  <= 1'b0;
            le_prev    <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], pi_sclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], pi_sdata};
            le_sync    <= {le_sync[SYNC_STAGES-2:0], pi_le};
            sclk_prev  <= sclk_sync[SYNC_STAGES-1];
            le_prev    <= le_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign le_rise    = le_sync[SYNC_STAGES-1] & ~le_prev;
    assign le_fall    = ~le_sync[SYNC_STAGES-1] & le_prev;
    assign sdata_bit  = sdata_sync[SYNC_STAGES-1];
    assign shift_word = {shreg, sdata_bit};
    assign hdr_bad    = (shift_word >> ADDR_W) != 16'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_shift   = 1'b0;
        hdr_load   = 1'b0;
        byte_load  = 1'b0;
        frame_end  = 1'b0;
        frame_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (le_rise) begin
                    start      = 1'b1;
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (sclk_rise) begin
                    do_shift = 1'b1;
                    if (bit_cnt == 4'd15) begin
                        hdr_load   = 1'b1;
                        state_next = S_DATA;
                    end
                end
                // The bit arriving with the frame end is shifted first; only a still-incomplete header is an error.
                if (le_fall) begin
                    frame_end  = 1'b1;
                    frame_err  = ~hdr_load;
                    state_next = S_DONE;
                end
            end
            S_DATA: begin
                if (sclk_rise) begin
                    do_shift = 1'b1;
                    if (bit_cnt[2:0] == 3'd7) begin
                        byte_load = 1'b1;
                    end
                end
                if (le_fall) begin
                    frame_end  = 1'b1;
                    frame_err  = ~byte_load & (do_shift | (bit_cnt != 4'd0));
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            addr_cnt <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
        end else begin
            ram_we <= 1'b0;

            if (start) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                checksum <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                busy     <= 1'b1;
            end

            if (do_shift) begin
                shreg   <= shift_word[14:0];
                bit_cnt <= (hdr_load || byte_load) ? 4'd0 : bit_cnt + 4'd1;
            end

            if (hdr_load) begin
                addr_cnt <= shift_word[ADDR_W-1:0];
                if (hdr_bad) begin
                    error <= 1'b1;
                end
            end

            // ram_addr is a separate copy so it stays put while addr_cnt advances after the pulse.
            if (byte_load) begin
                ram_we   <= 1'b1;
                ram_data <= shift_word[7:0];
                ram_addr <= addr_cnt;
            end

            if (ram_we) begin
                addr_cnt <= addr_cnt + 1'b1;
                checksum <= checksum + ram_data;
            end

            if (frame_end) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (frame_err) begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsr_loader.sv
// Self-checking bench for dsr_loader: directed frames from the test plan plus random frames,
// scored against a frame-level model working on the raw bit list.
module tb_dsr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        pi_sclk;
    logic        pi_sdata;
    logic        pi_le;
    logic        ram_we;
    logic [0:12] ram_addr;
    logic [0:7]  ram_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [0:7]  checksum;

    always #5 clk = ~clk;

    dsr_loader #(.ADDR_W(13), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .pi_sclk  (pi_sclk),
        .pi_sdata (pi_sdata),
        .pi_le    (pi_le),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit          frame_bits[$];
    logic [12:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    logic [12:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic        exp_err;
    logic [7:0]  exp_sum;

    always @(negedge clk) begin
        if (ram_we) begin
            obs_addr.push_back(ram_addr);
            obs_data.push_back(ram_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_bits(input logic [15:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            frame_bits.push_back(value[i]);
        end
    endtask

    // Frame-level model: header, whole bytes, leftover bits, all by plain arithmetic.
    task automatic model_frame();
        int n;
        int hdr;
        int base;
        int nbytes;
        int sum;
        int b;
        n = frame_bits.size();
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        sum = 0;
        if (n < 16) begin
            exp_err = 1'b1;
        end else begin
            hdr = 0;
            for (int i = 0; i < 16; i++) hdr = hdr * 2 + int'(frame_bits[i]);
            if (hdr >= 8192) exp_err = 1'b1;
            base   = hdr % 8192;
            nbytes = (n - 16) / 8;
            if ((n - 16) % 8 != 0) exp_err = 1'b1;
            for (int k = 0; k < nbytes; k++) begin
                b = 0;
                for (int j = 0; j < 8; j++) b = b * 2 + int'(frame_bits[16 + 8 * k + j]);
                exp_addr.push_back(13'((base + k) % 8192));
                exp_data.push_back(8'(b));
                sum = sum + b;
            end
        end
        exp_sum = 8'(sum % 256);
    endtask

    task automatic drive_bits(input bit simul);
        int n;
        n = frame_bits.size();
        for (int i = 0; i < n; i++) begin
            pi_sdata = frame_bits[i];
            wait_clk(2);
            pi_sclk = 1'b1;
            if (simul && i == n - 1) pi_le = 1'b0;
            wait_clk(5);
            pi_sclk = 1'b0;
            wait_clk(5);
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
    endtask

    task automatic send_frame(input string tag, input bit simul);
        obs_addr.delete();
        obs_data.delete();
        pi_le = 1'b1;
        wait_clk(6);
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_done_start"}, done, 1'b0);
        check({tag, "_err_start"}, error, 1'b0);
        check({tag, "_sum_start"}, checksum, 8'h00);
        drive_bits(simul && frame_bits.size() > 0);
        if (pi_le) begin
            wait_clk(1);
            pi_le = 1'b0;
        end
        wait_clk(10);
        model_frame();
        compare_writes(tag);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_checksum"}, checksum, exp_sum);
    endtask

    initial begin
        logic [15:0] hdr;
        logic [7:0]  byt;
        int          nb;
        int          extra;
        int          keep;

        reset    = 1'b1;
        pi_sclk  = 1'b0;
        pi_sdata = 1'b0;
        pi_le    = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        check("rst_we", ram_we, 1'b0);
        check("rst_addr", ram_addr, 13'h0);
        check("rst_data", ram_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_sum", checksum, 8'h00);

        frame_bits.delete();
        push_bits(16'h0000, 16); push_bits(16'h00AA, 8);
        send_frame("single", 1'b0);

        frame_bits.delete();
        push_bits(16'h1000, 16);
        push_bits(16'h01, 8); push_bits(16'h02, 8); push_bits(16'h03, 8); push_bits(16'hFF, 8);
        send_frame("burst", 1'b0);
        check("burst_sum_const", checksum, 8'h05);

        frame_bits.delete();
        push_bits(16'h1FFF, 16); push_bits(16'h11, 8); push_bits(16'h22, 8);
        send_frame("wrap", 1'b0);

        frame_bits.delete();
        push_bits(16'hE005, 16); push_bits(16'h3C, 8);
        send_frame("badhdr", 1'b0);

        frame_bits.delete();
        push_bits(16'h0010, 16); push_bits(16'h15, 5);
        send_frame("partial", 1'b0);

        // Reset in the middle of a byte, with pi_le dropped alongside it.
        frame_bits.delete();
        push_bits(16'h0100, 16); push_bits(16'hA, 4);
        obs_addr.delete();
        obs_data.delete();
        pi_le = 1'b1;
        wait_clk(6);
        drive_bits(1'b0);
        reset = 1'b1;
        pi_le = 1'b0;
        wait_clk(1);
        reset = 1'b0;
        check("midrst_we", ram_we, 1'b0);
        check("midrst_addr", ram_addr, 13'h0);
        check("midrst_data", ram_data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_error", error, 1'b0);
        check("midrst_sum", checksum, 8'h00);
        wait_clk(10);
        check("midrst_nowrite", obs_addr.size(), 0);
        check("midrst_idle", busy, 1'b0);

        frame_bits.delete();
        push_bits(16'h0200, 16); push_bits(16'h5A, 8);
        send_frame("after_rst", 1'b0);

        frame_bits.delete();
        push_bits(16'h0300, 16); push_bits(16'hC3, 8);
        send_frame("simul", 1'b1);

        obs_addr.delete();
        obs_data.delete();
        for (int i = 0; i < 20; i++) begin
            pi_sdata = 1'($urandom);
            wait_clk(2);
            pi_sclk = 1'b1;
            wait_clk(5);
            pi_sclk = 1'b0;
            wait_clk(5);
        end
        wait_clk(5);
        check("noise_nowrite", obs_addr.size(), 0);
        check("noise_busy", busy, 1'b0);
        check("noise_done", done, 1'b1);
        check("noise_error", error, exp_err);
        check("noise_sum", checksum, exp_sum);

        for (int r = 0; r < 10; r++) begin
            hdr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) hdr[15:13] = 3'b000;
            nb    = int'($urandom_range(0, 4));
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            frame_bits.delete();
            push_bits(hdr, 16);
            for (int k = 0; k < nb; k++) begin
                byt = 8'($urandom);
                push_bits({8'h00, byt}, 8);
            end
            if (extra > 0) push_bits(16'($urandom), extra);
            if ($urandom_range(0, 7) == 0) begin
                keep = int'($urandom_range(0, 15));
                while (frame_bits.size() > keep) void'(frame_bits.pop_back());
            end
            send_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
